mandelbrot_coord_gen: RTL and testbench

//  Per-frame coordinate generator directly upstream of the Mandelbrot iteration core, in the man_clk domain.
//  On a rising edge of init it latches frame origin/steps and walks all HRES*VRES pixels in raster order.

---
 rtl/mandelbrot_pkg.sv | 12 +
 rtl/mandelbrot_scr_cnt.sv | 39 +++
 rtl/mandelbrot_coord_gen.sv | 118 +++++++++++
 tb/tb_mandelbrot_coord_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types and default geometry for the Mandelbrot datapath and video pipe.
package mandelbrot_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} man_state_t;

  localparam int MAN_FPW  = 54;
  localparam int MAN_HRES = 800;
  localparam int MAN_VRES = 600;
  localparam int MAN_CW   = 12;
  localparam int MAN_AW   = 19;

endpackage

// File: rtl/mandelbrot_scr_cnt.sv
// Raster position counter: hcnt walks a line, vcnt walks the frame, both wrap to 0.
module mandelbrot_scr_cnt
  import mandelbrot_pkg::*;
#(
  parameter int HRES = MAN_HRES,
  parameter int VRES = MAN_VRES,
  parameter int CW   = MAN_CW
) (
  input  logic          man_clk,
  input  logic          man_rst,
  input  logic          step,
  input  logic          clear,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          line_end,
  output logic          frame_end
);

  assign line_end  = (hcnt == CW'(HRES - 1));
  assign frame_end = line_end && (vcnt == CW'(VRES - 1));

  always_ff @(posedge man_clk or posedge man_rst) begin
    if (man_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (clear) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (step) begin
      if (line_end) begin
        hcnt <= '0;
        vcnt <= frame_end ? '0 : vcnt + CW'(1);
      end else begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mandelbrot_coord_gen.sv
// Per-frame raster coordinate generator feeding the iteration core over valid/ready.
module mandelbrot_coord_gen
  import mandelbrot_pkg::*;
#(
  parameter int FPW  = MAN_FPW,
  parameter int HRES = MAN_HRES,
  parameter int VRES = MAN_VRES,
  parameter int CW   = MAN_CW,
  parameter int AW   = MAN_AW
) (
  input  logic                  man_clk,
  input  logic                  man_rst,
  input  logic                  clk_en,
  input  logic                  init,
  input  logic signed [FPW-1:0] man_x0,
  input  logic signed [FPW-1:0] man_y0,
  input  logic signed [FPW-1:0] man_xs,
  input  logic signed [FPW-1:0] man_ys,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic signed [FPW-1:0] out_cx,
  output logic signed [FPW-1:0] out_cy,
  output logic [AW-1:0]         out_adr,
  output logic                  busy,
  output logic                  done
);

  man_state_t            state;
  logic                  init_d;
  logic                  start;
  logic                  accept;
  logic signed [FPW-1:0] x0_r;
  logic signed [FPW-1:0] xs_r;
  logic signed [FPW-1:0] ys_r;
  logic [CW-1:0]         hcnt;
  logic [CW-1:0]         vcnt;
  logic                  line_end;
  logic                  frame_end;
  logic                  unused_cnt;

  assign start      = init & ~init_d;
  assign accept     = out_vld & out_rdy & clk_en;
  assign unused_cnt = ^{hcnt, vcnt};

  mandelbrot_scr_cnt #(
    .HRES (HRES),
    .VRES (VRES),
    .CW   (CW)
  ) u_scr_cnt (
    .man_clk   (man_clk),
    .man_rst   (man_rst),
    .step      (accept & ~start),
    .clear     (clk_en & (start | (state == LOAD))),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Frame parameters are data only; they are captured once per frame in LOAD.
  always_ff @(posedge man_clk) begin
    if (clk_en && !start && state == LOAD) begin
      x0_r <= man_x0;
      xs_r <= man_xs;
      ys_r <= man_ys;
    end
  end

  always_ff @(posedge man_clk or posedge man_rst) begin
    if (man_rst) begin
      state   <= IDLE;
      init_d  <= 1'b0;
      out_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out_cx  <= '0;
      out_cy  <= '0;
      out_adr <= '0;
    end else if (clk_en) begin
      init_d <= init;
      if (start) begin
        // A new frame always wins, dropping whatever pixel was pending.
        state   <= LOAD;
        out_vld <= 1'b0;
        busy    <= 1'b1;
        done    <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            state   <= RUN;
            out_vld <= 1'b1;
            out_cx  <= man_x0;
            out_cy  <= man_y0;
            out_adr <= '0;
          end
          RUN: begin
            if (accept) begin
              out_adr <= out_adr + AW'(1);
              if (frame_end) begin
                state   <= DONE;
                out_vld <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else if (line_end) begin
                out_cx <= x0_r;
                out_cy <= out_cy - ys_r;
              end else begin
                out_cx <= out_cx + xs_r;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Scoreboard bench for mandelbrot_coord_gen on a 4x3 frame with 16-bit coordinates.
module tb_mandelbrot_coord_gen;

  localparam int FPW  = 16;
  localparam int HRES = 4;
  localparam int VRES = 3;
  localparam int CW   = 4;
  localparam int AW   = 4;

  logic           man_clk = 1'b0;
  logic           man_rst;
  logic           clk_en;
  logic           init;
  logic [FPW-1:0] man_x0, man_y0, man_xs, man_ys;
  logic           out_vld;
  logic           out_rdy;
  logic [FPW-1:0] out_cx, out_cy;
  logic [AW-1:0]  out_adr;
  logic           busy, done;

  typedef struct packed {
    logic [FPW-1:0] cx;
    logic [FPW-1:0] cy;
    logic [AW-1:0]  adr;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    beat_cnt = 0;
  bit    chk_stable = 0;
  bit    prev_hold = 0;
  logic [FPW-1:0] prv_cx, prv_cy;
  logic [AW-1:0]  prv_adr;

  always #5 man_clk = ~man_clk;

  mandelbrot_coord_gen #(
    .FPW (FPW), .HRES (HRES), .VRES (VRES), .CW (CW), .AW (AW)
  ) dut (
    .man_clk (man_clk), .man_rst (man_rst), .clk_en (clk_en), .init (init),
    .man_x0 (man_x0), .man_y0 (man_y0), .man_xs (man_xs), .man_ys (man_ys),
    .out_vld (out_vld), .out_rdy (out_rdy), .out_cx (out_cx), .out_cy (out_cy),
    .out_adr (out_adr), .busy (busy), .done (done)
  );

  // Mid-cycle monitor: pops the scoreboard on every handshake and watches hold stability.
  always @(negedge man_clk) begin : mon
    beat_t e;
    if (chk_stable && prev_hold && out_vld) begin
      checks++;
      if ({out_cx, out_cy, out_adr} !== {prv_cx, prv_cy, prv_adr}) begin
        errors++;
        $display("FAIL stall_hold: got cx=%h cy=%h adr=%0d, held cx=%h cy=%h adr=%0d",
                 out_cx, out_cy, out_adr, prv_cx, prv_cy, prv_adr);
      end
    end
    if (out_vld && out_rdy && clk_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat: got adr=%0d cx=%h, expected no beat", out_adr, out_cx);
      end else begin
        e = sb.pop_front();
        if (out_cx !== e.cx || out_cy !== e.cy || out_adr !== e.adr) begin
          errors++;
          $display("FAIL beat: got cx=%h cy=%h adr=%0d, expected cx=%h cy=%h adr=%0d",
                   out_cx, out_cy, out_adr, e.cx, e.cy, e.adr);
        end
      end
      beat_cnt++;
      prev_hold = 1'b0;
    end else begin
      prev_hold = out_vld;
    end
    prv_cx  = out_cx;
    prv_cy  = out_cy;
    prv_adr = out_adr;
  end

  task automatic cyc();
    @(posedge man_clk);
    #1;
  endtask

  task automatic push_frame(input logic [FPW-1:0] x0, input logic [FPW-1:0] y0,
                            input logic [FPW-1:0] xs, input logic [FPW-1:0] ys);
    beat_t b;
    man_x0 = x0; man_y0 = y0; man_xs = xs; man_ys = ys;
    for (int v = 0; v < VRES; v++) begin
      for (int h = 0; h < HRES; h++) begin
        b.cx  = x0 + FPW'(h) * xs;
        b.cy  = y0 - FPW'(v) * ys;
        b.adr = AW'(v * HRES + h);
        sb.push_back(b);
      end
    end
    beat_cnt = 0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (done !== 1'b1 && n < budget);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
    end
  endtask

  task automatic test_reset();
    man_rst = 1'b1; clk_en = 1'b1; init = 1'b0; out_rdy = 1'b0;
    man_x0 = '0; man_y0 = '0; man_xs = '0; man_ys = '0;
    repeat (3) cyc();
    checks++;
    if ({out_vld, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got vld/busy/done=%b, expected 000", {out_vld, busy, done});
    end
    checks++;
    if ({out_cx, out_cy, out_adr} !== '0) begin
      errors++; $display("FAIL reset_data: got cx=%h cy=%h adr=%0d, expected 0", out_cx, out_cy, out_adr);
    end
    man_rst = 1'b0;
    repeat (2) cyc();
    checks++;
    if (busy !== 1'b0 || out_vld !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got busy=%b vld=%b, expected 0 0", busy, out_vld);
    end
  endtask

  task automatic test_basic();
    int n;
    push_frame(16'h0100, 16'h0080, 16'h0010, 16'h0008);
    out_rdy = 1'b1;
    init = 1'b1;
    cyc();
    init = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL load_state: got vld=%b busy=%b, expected 0 1", out_vld, busy);
    end
    cyc();
    checks++;
    if (out_vld !== 1'b1) begin
      errors++; $display("FAIL first_vld: got vld=%b, expected 1", out_vld);
    end
    wait_done(40, n);
    checks++;
    if (n != 12) begin
      errors++; $display("FAIL done_latency: got %0d cycles, expected 12", n);
    end
    checks++;
    if (beat_cnt != 12 || sb.size() != 0) begin
      errors++; $display("FAIL basic_count: got %0d beats, %0d left, expected 12, 0", beat_cnt, sb.size());
    end
    repeat (3) cyc();
    checks++;
    if ({done, busy, out_vld} !== 3'b100) begin
      errors++; $display("FAIL done_hold: got done/busy/vld=%b, expected 100", {done, busy, out_vld});
    end
  endtask

  task automatic test_backpressure();
    push_frame(16'h0100, 16'h0080, 16'h0010, 16'h0008);
    chk_stable = 1'b1;
    init = 1'b1;
    cyc();
    init = 1'b0;
    for (int i = 0; i < 300 && done !== 1'b1; i++) begin
      out_rdy = 1'($urandom_range(0, 1));
      cyc();
    end
    chk_stable = 1'b0;
    out_rdy = 1'b1;
    checks++;
    if (done !== 1'b1 || beat_cnt != 12 || sb.size() != 0) begin
      errors++; $display("FAIL bp_frame: got done=%b beats=%0d left=%0d, expected 1 12 0", done, beat_cnt, sb.size());
    end
  endtask

  task automatic test_abort();
    int n;
    push_frame(16'h0100, 16'h0080, 16'h0010, 16'h0008);
    out_rdy = 1'b1;
    init = 1'b1;
    cyc();
    init = 1'b0;
    n = 0;
    while (beat_cnt < 5 && n < 50) begin
      cyc();
      n++;
    end
    out_rdy = 1'b0;
    init = 1'b1;
    sb.delete();
    push_frame(16'h0200, 16'h0080, 16'h0010, 16'h0008);
    cyc();
    init = 1'b0;
    out_rdy = 1'b1;
    checks++;
    if (out_vld !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_load: got vld=%b done=%b busy=%b, expected 0 0 1", out_vld, done, busy);
    end
    cyc();
    checks++;
    if (out_vld !== 1'b1 || out_adr !== 4'd0 || out_cx !== 16'h0200) begin
      errors++; $display("FAIL abort_restart: got vld=%b adr=%0d cx=%h, expected 1 0 0200", out_vld, out_adr, out_cx);
    end
    wait_done(40, n);
    checks++;
    if (beat_cnt != 12 || sb.size() != 0) begin
      errors++; $display("FAIL abort_count: got %0d beats, %0d left, expected 12, 0", beat_cnt, sb.size());
    end
  endtask

  task automatic test_clk_en();
    int n;
    push_frame(16'h0100, 16'h0080, 16'h0010, 16'h0008);
    out_rdy = 1'b1;
    clk_en = 1'b1;
    init = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      clk_en = ~clk_en;
    end
    init = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      cyc();
      clk_en = ~clk_en;
      n++;
    end
    clk_en = 1'b1;
    checks++;
    if (done !== 1'b1 || beat_cnt != 12 || sb.size() != 0) begin
      errors++; $display("FAIL clken_frame: got done=%b beats=%0d left=%0d, expected 1 12 0", done, beat_cnt, sb.size());
    end
  endtask

  task automatic test_wrap_hold();
    push_frame(16'h7FF0, 16'h0000, 16'h0010, 16'h0001);
    out_rdy = 1'b1;
    init = 1'b1;
    repeat (20) cyc();
    init = 1'b0;
    repeat (3) cyc();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || beat_cnt != 12 || sb.size() != 0) begin
      errors++; $display("FAIL init_hold: got done=%b busy=%b beats=%0d left=%0d, expected 1 0 12 0",
                         done, busy, beat_cnt, sb.size());
    end
  endtask

  task automatic test_rst_mid();
    int n;
    push_frame(16'h0100, 16'h0080, 16'h0010, 16'h0008);
    out_rdy = 1'b1;
    init = 1'b1;
    cyc();
    init = 1'b0;
    n = 0;
    while (beat_cnt < 7 && n < 50) begin
      cyc();
      n++;
    end
    man_rst = 1'b1;
    cyc();
    checks++;
    if ({out_vld, done, busy} !== 3'b000 || out_adr !== 4'd0) begin
      errors++; $display("FAIL rst_mid: got vld/done/busy=%b adr=%0d, expected 000 0", {out_vld, done, busy}, out_adr);
    end
    man_rst = 1'b0;
    sb.delete();
    repeat (4) cyc();
    checks++;
    if (done !== 1'b0 || out_vld !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: got done=%b vld=%b, expected 0 0", done, out_vld);
    end
    push_frame(16'h0100, 16'h0080, 16'h0010, 16'h0008);
    init = 1'b1;
    cyc();
    init = 1'b0;
    wait_done(40, n);
    checks++;
    if (beat_cnt != 12 || sb.size() != 0) begin
      errors++; $display("FAIL rst_restart: got %0d beats, %0d left, expected 12, 0", beat_cnt, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_clk_en();
    test_wrap_hold();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
